// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
//   Bundles the ID-side inputs and EX-side outputs of the ALU issue stage.
//   master : the issue stage itself (reads ID fields, drives the EX register outputs)
//   slave  : the surrounding pipeline / bench (drives ID fields, observes EX outputs)
//   ID side : valid_i, stall_i, flush_i, alu_op_i, funct7_i, funct3_i,
//             rs1_data_i, rs2_data_i, imm_i, alu_src_i
//   EX side : valid_o, alu_ctl_o, a_o, b_o, illegal_o, ill_cnt_o
interface alu_issue_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic [1:0]        alu_op_i;
  logic [6:0]        funct7_i;
  logic [2:0]        funct3_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [DATA_W-1:0] imm_i;
  logic              alu_src_i;

  logic              valid_o;
  logic [2:0]        alu_ctl_o;
  logic [DATA_W-1:0] a_o;
  logic [DATA_W-1:0] b_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  ill_cnt_o;

  modport master (
    input  valid_i, stall_i, flush_i, alu_op_i, funct7_i, funct3_i,
           rs1_data_i, rs2_data_i, imm_i, alu_src_i,
    output valid_o, alu_ctl_o, a_o, b_o, illegal_o, ill_cnt_o
  );

  modport slave (
    output valid_i, stall_i, flush_i, alu_op_i, funct7_i, funct3_i,
           rs1_data_i, rs2_data_i, imm_i, alu_src_i,
    input  valid_o, alu_ctl_o, a_o, b_o, illegal_o, ill_cnt_o
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Producer end of the ALU interface. Decodes ALUOp/funct7/funct3 into a 3-bit
//   ALU control code, selects and masks operand B, and registers control plus
//   operands into the EX stage with valid/stall/flush handling. Undecodable
//   valid instructions are flagged and counted by a saturating counter.
//   Code 3'b111 is never produced.
// Ports
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : alu_issue_stage_if.master (ID-side fields in, EX register out)
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_issue_stage_if.master     bus
);

  localparam logic [2:0] CTL_AND  = 3'b000;
  localparam logic [2:0] CTL_XOR  = 3'b001;
  localparam logic [2:0] CTL_SLL  = 3'b010;
  localparam logic [2:0] CTL_ADD  = 3'b011;
  localparam logic [2:0] CTL_SUB  = 3'b100;
  localparam logic [2:0] CTL_MUL  = 3'b101;
  localparam logic [2:0] CTL_SRAI = 3'b110;

  logic [2:0]        dec_ctl;
  logic              dec_ill;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] b_next;

  logic              valid_q;
  logic [2:0]        ctl_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              ill_q;
  logic [CNT_W-1:0]  cnt_q;

  // Decode: anything not explicitly listed falls back to add and is flagged
  // illegal, so the ALU always sees a defined code.
  always_comb begin
    dec_ctl = CTL_ADD;
    dec_ill = 1'b0;
    case (bus.alu_op_i)
      2'b00: dec_ctl = CTL_ADD;
      2'b01: dec_ctl = CTL_SUB;
      2'b10: begin
        case ({bus.funct7_i, bus.funct3_i})
          {7'b0000000, 3'b111}: dec_ctl = CTL_AND;
          {7'b0000000, 3'b100}: dec_ctl = CTL_XOR;
          {7'b0000000, 3'b001}: dec_ctl = CTL_SLL;
          {7'b0000000, 3'b000}: dec_ctl = CTL_ADD;
          {7'b0100000, 3'b000}: dec_ctl = CTL_SUB;
          {7'b0000001, 3'b000}: dec_ctl = CTL_MUL;
          default:              dec_ill = 1'b1;
        endcase
      end
      default: begin
        if (bus.funct3_i == 3'b000) begin
          dec_ctl = CTL_ADD;
        end else if (bus.funct7_i == 7'b0100000 && bus.funct3_i == 3'b101) begin
          dec_ctl = CTL_SRAI;
        end else begin
          dec_ill = 1'b1;
        end
      end
    endcase
  end

  // Shifts only use the low five bits of B; clearing the rest keeps the ALU
  // from seeing the funct7 bits that ride along in the shift immediate.
  always_comb begin
    b_sel  = bus.alu_src_i ? bus.imm_i : bus.rs2_data_i;
    b_next = b_sel;
    if (dec_ctl == CTL_SLL || dec_ctl == CTL_SRAI) begin
      b_next = {{(DATA_W-5){1'b0}}, b_sel[4:0]};
    end
  end

  // EX register: flush beats stall beats load. The illegal counter only moves
  // on a real load of an illegal instruction and sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_ADD;
      a_q     <= '0;
      b_q     <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.flush_i || (!bus.stall_i && !bus.valid_i)) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_ADD;
      a_q     <= '0;
      b_q     <= '0;
      ill_q   <= 1'b0;
    end else if (!bus.stall_i) begin
      valid_q <= 1'b1;
      ctl_q   <= dec_ctl;
      a_q     <= bus.rs1_data_i;
      b_q     <= b_next;
      ill_q   <= dec_ill;
      if (dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.alu_ctl_o = ctl_q;
  assign bus.a_o       = a_q;
  assign bus.b_o       = b_q;
  assign bus.illegal_o = ill_q;
  assign bus.ill_cnt_o = cnt_q;

endmodule
